// File: rtl/load_hazard_unit.sv
// Load-use hazard and pipeline-freeze controller for the 5-stage core.
// Tracks in-flight loads for LOAD_LAT cycles and steers PC, IF/ID and ID/EX control.
module load_hazard_unit #(
  parameter int              REG_W       = 4,
  parameter int              OP_W        = 3,
  parameter int              LOAD_LAT    = 1,
  parameter logic [OP_W-1:0] NO_RT_OP0   = OP_W'(3'b011),
  parameter logic [OP_W-1:0] NO_RT_OP1   = OP_W'(3'b110),
  parameter bit              ZERO_REG_EN = 1'b1,
  parameter int              CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [OP_W-1:0]  id_op,
  input  logic             mem_busy,
  input  logic             branch_taken,
  input  logic             stat_clr,
  output logic             pc_write_en,
  output logic             ifid_write_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             pipe_freeze,
  output logic [CNT_W-1:0] stall_cnt
);

  // With LOAD_LAT=1 there are no pending entries; one dummy slot is kept
  // so the array stays legal, and its valid bit is never set.
  localparam bit HAS_PEND = (LOAD_LAT > 1);
  localparam int PEND_N   = HAS_PEND ? (LOAD_LAT - 1) : 1;

  typedef enum logic {
    ST_RESET,
    ST_RUN
  } state_e;

  typedef enum logic [2:0] {
    SEL_RESET,
    SEL_FREEZE,
    SEL_BRANCH,
    SEL_STALL,
    SEL_RUN
  } sel_e;

  state_e           stateQ;
  state_e           stateD;
  sel_e             sel;
  logic [PEND_N-1:0] pendValid;
  logic [REG_W-1:0] pendRd [PEND_N];
  logic [CNT_W-1:0] cntQ;
  logic             rsMatch;
  logic             rtMatch;
  logic             usesRt;
  logic             hazard;

  // Control stays at its reset values until the first edge after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ <= ST_RESET;
    end else begin
      stateQ <= stateD;
    end
  end

  always_comb begin
    stateD = stateQ;
    case (stateQ)
      ST_RESET: stateD = ST_RUN;
      ST_RUN:   stateD = ST_RUN;
      default:  stateD = ST_RESET;
    endcase
  end

  // Pending-load shift register; held while the pipe is frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pendValid <= '0;
      for (int k = 0; k < PEND_N; k++) begin
        pendRd[k] <= '0;
      end
    end else if (!pipe_freeze) begin
      pendValid[0] <= ex_mem_read && HAS_PEND;
      pendRd[0]    <= ex_rt;
      for (int k = 1; k < PEND_N; k++) begin
        pendValid[k] <= pendValid[k-1];
        pendRd[k]    <= pendRd[k-1];
      end
    end
  end

  always_comb begin
    rsMatch = ex_mem_read && (ex_rt == id_rs);
    rtMatch = ex_mem_read && (ex_rt == id_rt);
    for (int k = 0; k < PEND_N; k++) begin
      if (pendValid[k] && (pendRd[k] == id_rs)) rsMatch = 1'b1;
      if (pendValid[k] && (pendRd[k] == id_rt)) rtMatch = 1'b1;
    end
    if (ZERO_REG_EN && (id_rs == '0)) rsMatch = 1'b0;
    if (ZERO_REG_EN && (id_rt == '0)) rtMatch = 1'b0;
    usesRt = (id_op != NO_RT_OP0) && (id_op != NO_RT_OP1);
    hazard = id_valid && (rsMatch || (usesRt && rtMatch));
  end

  // Fixed priority: reset, memory freeze, taken branch, load-use stall.
  always_comb begin
    sel = SEL_RUN;
    if (stateQ == ST_RESET) begin
      sel = SEL_RESET;
    end else if (mem_busy) begin
      sel = SEL_FREEZE;
    end else if (branch_taken) begin
      sel = SEL_BRANCH;
    end else if (hazard) begin
      sel = SEL_STALL;
    end
  end

  always_comb begin
    pc_write_en   = 1'b1;
    ifid_write_en = 1'b1;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    pipe_freeze   = 1'b0;
    case (sel)
      SEL_RESET: begin
        pc_write_en   = 1'b0;
        ifid_write_en = 1'b0;
        ifid_flush    = 1'b1;
        idex_flush    = 1'b1;
      end
      SEL_FREEZE: begin
        pc_write_en   = 1'b0;
        ifid_write_en = 1'b0;
        pipe_freeze   = 1'b1;
      end
      SEL_BRANCH: begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end
      SEL_STALL: begin
        pc_write_en   = 1'b0;
        ifid_write_en = 1'b0;
        idex_flush    = 1'b1;
      end
      default: begin
        pc_write_en   = 1'b1;
        ifid_write_en = 1'b1;
      end
    endcase
  end

  // Saturating stall counter; a clear in a stall cycle discards that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cntQ <= '0;
    end else if (stat_clr) begin
      cntQ <= '0;
    end else if ((sel == SEL_STALL) && (cntQ != {CNT_W{1'b1}})) begin
      cntQ <= cntQ + 1'b1;
    end
  end

  assign stall_cnt = cntQ;

endmodule
